// File: rtl/decode_stage.sv
// decode_stage: IF/ID pipeline register, instruction decoder, 32x32 register file
// with write-through reads, and early branch/jump resolution back to fetch.
module decode_stage #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int INSTR_WIDTH   = 32
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic [INSTR_WIDTH-1:0]   i_InstrF,
  input  logic [ADDRESS_WIDTH-1:0] i_PCPlus4F,
  input  logic                     i_StallD,
  input  logic                     i_ForwardAD,
  input  logic                     i_ForwardBD,
  input  logic [31:0]              i_ALUOutM,
  input  logic                     i_RegWriteW,
  input  logic [4:0]               i_WriteRegW,
  input  logic [31:0]              i_ResultW,
  output logic [ADDRESS_WIDTH-1:0] o_PCBranchD,
  output logic                     o_PCSrcD,
  output logic                     o_RegWriteD,
  output logic                     o_MemtoRegD,
  output logic                     o_MemWriteD,
  output logic                     o_ALUSrcD,
  output logic                     o_RegDstD,
  output logic                     o_BranchD,
  output logic                     o_JumpD,
  output logic [2:0]               o_ALUControlD,
  output logic [31:0]              o_RD1D,
  output logic [31:0]              o_RD2D,
  output logic [4:0]               o_RsD,
  output logic [4:0]               o_RtD,
  output logic [4:0]               o_RdD,
  output logic [31:0]              o_SignImmD
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
  logic [ADDRESS_WIDTH-1:0] pc4_q, pc4_d;
  logic [31:0]              rf_q [32];
  logic [31:0]              rf_d [32];
  logic                     wr_en;
  logic [31:0]              cmp_a, cmp_b;
  logic [5:0]               opcode, funct;

  assign opcode     = instr_q[31:26];
  assign funct      = instr_q[5:0];
  assign o_RsD      = instr_q[25:21];
  assign o_RtD      = instr_q[20:16];
  assign o_RdD      = instr_q[15:11];
  assign o_SignImmD = {{16{instr_q[15]}}, instr_q[15:0]};
  assign wr_en      = i_RegWriteW && (i_WriteRegW != 5'd0);

  // IF/ID next value: stall holds (even over a taken branch), taken branch flushes
  always_comb begin
    instr_d = i_InstrF;
    pc4_d   = i_PCPlus4F;
    if (i_StallD) begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
    end else if (o_PCSrcD) begin
      instr_d = '0;
      pc4_d   = '0;
    end
  end

  // IF/ID register; reset wins over stall and flush
  always_ff @(posedge i_CLK) begin
    if (!i_RST) begin
      instr_q <= '0;
      pc4_q   <= '0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  // Register file next state; $0 is never written so it stays 0 after reset
  always_comb begin
    rf_d = rf_q;
    if (wr_en) rf_d[i_WriteRegW] = i_ResultW;
  end

  // Register file storage
  always_ff @(posedge i_CLK) begin
    if (!i_RST) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Combinational reads with write-through of the same-cycle writeback
  always_comb begin
    o_RD1D = (o_RsD == 5'd0) ? 32'd0 : rf_q[o_RsD];
    o_RD2D = (o_RtD == 5'd0) ? 32'd0 : rf_q[o_RtD];
    if (wr_en && (i_WriteRegW == o_RsD)) o_RD1D = i_ResultW;
    if (wr_en && (i_WriteRegW == o_RtD)) o_RD2D = i_ResultW;
  end

  // Main/ALU decoder; anything unrecognised becomes a bubble
  always_comb begin
    o_RegWriteD   = 1'b0;
    o_MemtoRegD   = 1'b0;
    o_MemWriteD   = 1'b0;
    o_ALUSrcD     = 1'b0;
    o_RegDstD     = 1'b0;
    o_BranchD     = 1'b0;
    o_JumpD       = 1'b0;
    o_ALUControlD = 3'b000;
    unique case (opcode)
      OP_RTYPE: begin
        unique case (funct)
          6'b100000: o_ALUControlD = 3'b010;
          6'b100010: o_ALUControlD = 3'b110;
          6'b100100: o_ALUControlD = 3'b000;
          6'b100101: o_ALUControlD = 3'b001;
          6'b101010: o_ALUControlD = 3'b111;
          default:   o_ALUControlD = 3'b000;
        endcase
        if (funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) begin
          o_RegWriteD = 1'b1;
          o_RegDstD   = 1'b1;
        end
      end
      OP_LW: begin
        o_RegWriteD   = 1'b1;
        o_ALUSrcD     = 1'b1;
        o_MemtoRegD   = 1'b1;
        o_ALUControlD = 3'b010;
      end
      OP_SW: begin
        o_MemWriteD   = 1'b1;
        o_ALUSrcD     = 1'b1;
        o_ALUControlD = 3'b010;
      end
      OP_BEQ: begin
        o_BranchD     = 1'b1;
        o_ALUControlD = 3'b110;
      end
      OP_ADDI: begin
        o_RegWriteD   = 1'b1;
        o_ALUSrcD     = 1'b1;
        o_ALUControlD = 3'b010;
      end
      OP_J:    o_JumpD = 1'b1;
      default: ;
    endcase
  end

  // Early branch resolution with MEM-stage forwarding into the comparator
  always_comb begin
    cmp_a    = i_ForwardAD ? i_ALUOutM : o_RD1D;
    cmp_b    = i_ForwardBD ? i_ALUOutM : o_RD2D;
    o_PCSrcD = (o_BranchD && (cmp_a == cmp_b)) || o_JumpD;
    if (o_JumpD)
      o_PCBranchD = {pc4_q[ADDRESS_WIDTH-1 -: 4], instr_q[25:0], 2'b00};
    else
      o_PCBranchD = pc4_q + {o_SignImmD[29:0], 2'b00};
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Second stage of the five-stage MIPS pipeline, directly downstream of the fetch stage. It holds the IF/ID pipeline register, decodes the latched instruction into control signals, and reads and writes the 32×32 register file. It also resolves branches and jumps early in decode and returns the branch target and select to fetch (`PCBranchD`/`PCSrcD`). Outputs feed the ID/EX register and the hazard unit.

## Interface
- `ADDRESS_WIDTH`, 32, PC width
- `INSTR_WIDTH`, 32, instruction width
- `i_CLK`  in  1  clock; all state updates on rising edge
- `i_RST`  in  1  reset, synchronous, active-low
- `i_InstrF`  in  32  instruction from fetch
- `i_PCPlus4F`  in  32  PC+4 from fetch
- `i_StallD`  in  1  hold IF/ID register
- `i_ForwardAD`, `i_ForwardBD`  in  1 each  select `i_ALUOutM` for branch comparator operand A/B
- `i_ALUOutM`  in  32  MEM-stage ALU result
- `i_RegWriteW`  in  1  writeback enable
- `i_WriteRegW`  in  5  writeback register
- `i_ResultW`  in  32  writeback data
- `o_PCBranchD`  out  32  next-PC target (branch or jump)
- `o_PCSrcD`  out  1  take `o_PCBranchD`
- `o_RegWriteD`, `o_MemtoRegD`, `o_MemWriteD`, `o_ALUSrcD`, `o_RegDstD`, `o_BranchD`, `o_JumpD`  out  1 each  control
- `o_ALUControlD`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- `o_RD1D`, `o_RD2D`  out  32  register-file read data
- `o_RsD`, `o_RtD`, `o_RdD`  out  5  instr[25:21], [20:16], [15:11]
- `o_SignImmD`  out  32  sign-extended instr[15:0]

## Operation
- IF/ID register holds `InstrD` and `PCPlus4D`. Update priority per edge:
  - reset (`i_RST`=0): both cleared to 0.
  - else `i_StallD`=1: hold.
  - else `o_PCSrcD`=1: flush, both cleared to 0.
  - else: load `i_InstrF`, `i_PCPlus4F`.
- Register file: 32×32.
  - Write on the rising edge when `i_RegWriteW`=1 and `i_WriteRegW`≠0.
  - Register 0 always reads 0 and is never written.
  - Reset clears all registers to 0.
- Reads are combinational with write-through: if `i_RegWriteW`=1, `i_WriteRegW`≠0 and `i_WriteRegW` equals the read address, return `i_ResultW`.
- Decoder (opcode/funct):
  - R-type 000000, funct 100000/100010/100100/100101/101010 (add/sub/and/or/slt): RegWrite=1, RegDst=1, ALUControl per funct.
  - Any other funct, including all-zero instruction: all control 0 (bubble).
  - lw 100011: RegWrite, ALUSrc, MemtoReg; add.
  - sw 101011: MemWrite, ALUSrc; add.
  - beq 000100: Branch; sub.
  - addi 001000: RegWrite, ALUSrc; add.
  - j 000010: Jump.
  - Unknown opcode: all control 0.
- Branch comparator:
  - A = `i_ForwardAD` ? `i_ALUOutM` : `o_RD1D`; B likewise with `i_ForwardBD`/`o_RD2D`.
  - Equal = (A==B).
- `o_PCSrcD` = (Branch & Equal) | Jump.
- `o_PCBranchD`:
  - Jump: {PCPlus4D[31:28], InstrD[25:0], 2'b00}.
  - Otherwise: PCPlus4D + (SignImm<<2), modulo 2^32 (wraps, no overflow flag).

## Timing
- IF/ID: one-cycle latency; instruction presented by fetch at edge N is decoded during cycle N+1.
- Reset values: IF/ID = 0.
  - All control outputs, `o_PCSrcD`, `o_RsD`/`o_RtD`/`o_RdD` and `o_SignImmD` are 0.
  - `o_RD1D`/`o_RD2D` = 0 (registers cleared).
  - `o_PCBranchD` = 0 + (0<<2) = 0.
- Reset asserted mid-stream overrides stall and flush on that edge.
- Decode, comparator, `o_PCSrcD` and `o_PCBranchD` are combinational from IF/ID and the register file; valid within the same cycle.
- Taken branch/jump costs exactly one bubble: the instruction fetched alongside it is flushed on the next edge.
- Stall together with `o_PCSrcD`=1: hold wins and no flush occurs. The hazard unit guarantees that fetch is stalled too.
- Writeback and a read of the same register in the same cycle: the read returns the new value.

## Test plan
- Reset low for 2 cycles with `i_InstrF`=0x8C080004 → all outputs 0. Release; next edge → `o_MemtoRegD`=1, `o_RtD`=8, `o_SignImmD`=4.
- Write $5=0x12345678 via W port, then decode `add $3,$5,$0` (0x00A01820) → `o_RD1D`=0x12345678, `o_RegWriteD`=1, `o_ALUControlD`=010, `o_RdD`=3. Same-cycle write/read of $5 returns the new value; write to $0 → reads 0.
- beq with $1=$2=7, PCPlus4D=0x100, imm=0xFFFF → `o_PCSrcD`=1, `o_PCBranchD`=0xFC; IF/ID is 0 next cycle. With $2=8 → `o_PCSrcD`=0 and no flush.
- beq with RD1D=3, `i_ALUOutM`=9, `i_ForwardAD`=1, RD2D=9 → taken. Repeat with `i_StallD`=1 → IF/ID held, not flushed.
- j 0x0000040 with PCPlus4D=0xA0000004 → `o_PCBranchD`=0xA0000100, `o_JumpD`=1, `o_PCSrcD`=1.
- Stall held for 3 cycles while `i_InstrF` changes → IF/ID and outputs constant. Unsupported opcode 0x3F → all controls 0.
